mips32_regfile_mp: RTL and testbench

//  Parametrised multi-port register file; successor to the 2R/1W mips32 register file.

---
 rtl/mips32_regfile_mp.sv | 154 +++++++++++++++
 tb/tb_mips32_regfile_mp.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : mips32_regfile_mp
//  Description : Parametrised multi-port register file. NUM_RD combinational
//                read ports, two synchronous write ports (ALU and load
//                writeback) and a sequential scrub engine that zeroes one
//                entry per cycle after a clr_req pulse.
//  Ports       : clk      - clock, rising-edge state updates
//                reset    - synchronous active-high reset
//                rd_addr  - NUM_RD packed read addresses
//                rd_data  - NUM_RD packed read data
//                wr_en0/wr_addr0/wr_data0 - write port 0
//                wr_en1/wr_addr1/wr_data1 - write port 1 (wins on collision)
//                clr_req  - pulse to start a scrub
//                busy     - high while a scrub is in progress
//  Config      : REGFILE_BYPASS_EN - forward same-cycle write data to reads
//  Revision    : 1.0 - initial release
// ============================================================================
module mips32_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr_en0,
    input  logic [ADDR_W-1:0]          wr_addr0,
    input  logic [DATA_W-1:0]          wr_data0,
    input  logic                       wr_en1,
    input  logic [ADDR_W-1:0]          wr_addr1,
    input  logic [DATA_W-1:0]          wr_data1,
    input  logic                       clr_req,
    output logic                       busy
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic            c_zr      = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   w_idx_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_busy;
    logic                w_we0;
    logic                w_we1;

    assign w_busy = (r_state == S_CLEAR);
    assign busy   = w_busy;

    // A write takes effect only outside a scrub and, with a hard-wired zero
    // register, never to entry 0.
    assign w_we0 = wr_en0 && !w_busy && !(c_zr && (wr_addr0 == '0));
    assign w_we1 = wr_en1 && !w_busy && !(c_zr && (wr_addr1 == '0));

    // ------------------------------------------------------------------------
    // Scrub FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            S_CLEAR: begin
                // idx wraps to 0 on the same edge the scrub finishes.
                w_idx_nxt = r_idx + 1'b1;
                if (r_idx == c_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_busy) begin
            r_mem[r_idx] <= '0;
        end else begin
            if (w_we0) begin
                r_mem[wr_addr0] <= wr_data0;
            end
            // Port 1 is assigned last so it wins on an address collision.
            if (w_we1) begin
                r_mem[wr_addr1] <= wr_data1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_raddr;
            logic [DATA_W-1:0] w_rdata;

            assign w_raddr = rd_addr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                w_rdata = r_mem[w_raddr];
`ifdef REGFILE_BYPASS_EN
                // Port 1 checked last so its data wins when both match.
                if (w_we0 && (wr_addr0 == w_raddr)) begin
                    w_rdata = wr_data0;
                end
                if (w_we1 && (wr_addr1 == w_raddr)) begin
                    w_rdata = wr_data1;
                end
`endif
                if (c_zr && (w_raddr == '0)) begin
                    w_rdata = '0;
                end
            end

            assign rd_data[gi*DATA_W +: DATA_W] = w_rdata;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mips32_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips32_regfile_mp
//  Description : Self-checking bench for mips32_regfile_mp (default sizes,
//                ZERO_REG=1). Table-driven write/read vectors plus scripted
//                scrub and reset sequences; read expectations flow through a
//                scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips32_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int ZR = 1;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic              wr_en0, wr_en1;
    logic [AW-1:0]     wr_addr0, wr_addr1;
    logic [DW-1:0]     wr_data0, wr_data1;
    logic              clr_req;
    logic              busy;

    mips32_regfile_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(ZR)
    ) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .clr_req(clr_req), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      nm;
        int         port;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        we0; logic [4:0] a0; logic [31:0] d0;
        logic        we1; logic [4:0] a1; logic [31:0] d1;
        logic [4:0]  ra0; logic [4:0] ra1;
        logic [31:0] e0;  logic [31:0] e1;
    } vec_t;
    vec_t tbl[10];

    logic [31:0] model [DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input int port, input logic [31:0] exp);
        sb_t e;
        e.nm = nm; e.port = port; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.nm, rd_data[e.port*DW +: DW], e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
        wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
        clr_req = 1'b0;
    endtask

    task automatic model_wr(input logic [4:0] a, input logic [31:0] d);
        if (!(ZR != 0 && a == 5'd0)) model[a] = d;
    endtask

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) model[k] = '0;
    endtask

    // Reads every entry in pairs (sr, sr+1) and compares against the model.
    task automatic read_all(input string nm);
        for (int s = 0; s < DEPTH; s += 2) begin
            rd_addr = {5'(s + 1), 5'(s)};
            push(nm, 0, model[s]);
            push(nm, 1, model[s + 1]);
            @(negedge clk);
            drain();
        end
    endtask

    task automatic fill_all();
        for (int k = 0; k < DEPTH; k++) begin
            wr_en0 = 1'b1; wr_addr0 = 5'(k); wr_data0 = 32'(k + 1);
            model_wr(5'(k), 32'(k + 1));
            tick();
        end
        wr_en0 = 1'b0;
    endtask

    int busy_cnt;

    initial begin
        // Vector table: one row per cycle; expected values are the reads seen
        // in that cycle, with no read aimed at a same-cycle write target.
        tbl[0] = '{1'b1, 5'd7,  32'h11,   1'b1, 5'd7,  32'h22,   5'd1,  5'd2,  32'd10,   32'd20};
        tbl[1] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    5'd7,  5'd0,  32'h22,   32'h0};
        tbl[2] = '{1'b1, 5'd3,  32'h5,    1'b1, 5'd4,  32'h6,    5'd7,  5'd8,  32'h22,   32'd80};
        tbl[3] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    5'd3,  5'd4,  32'h5,    32'h6};
        tbl[4] = '{1'b1, 5'd0,  32'hdead, 1'b1, 5'd31, 32'h1234, 5'd3,  5'd30, 32'h5,    32'd300};
        tbl[5] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    5'd0,  5'd31, 32'h0,    32'h1234};
        tbl[6] = '{1'b1, 5'd12, 32'h77,   1'b1, 5'd0,  32'hbeef, 5'd31, 5'd11, 32'h1234, 32'd110};
        tbl[7] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    5'd0,  5'd12, 32'h0,    32'h77};
        tbl[8] = '{1'b0, 5'd5,  32'hffff, 1'b0, 5'd6,  32'heeee, 5'd5,  5'd6,  32'd50,   32'd60};
        tbl[9] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    5'd5,  5'd6,  32'd50,   32'd60};

        idle_inputs();
        rd_addr = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // ---- 1: reset after random writes ----
        for (int i = 0; i < 6; i++) begin
            wr_en0 = 1'b1; wr_addr0 = 5'($urandom_range(1, 31)); wr_data0 = $urandom;
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        read_all("reset_read");

        // ---- 2: write 10*k everywhere, read back ----
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            wr_en0 = 1'b1; wr_addr0 = 5'(k); wr_data0 = 32'(10 * k);
            model_wr(5'(k), 32'(10 * k));
            tick();
        end
        idle_inputs();
        read_all("write_read");

        // ---- 3: table vectors (collision, dual write, entry 0 discard) ----
        tick();
        for (int r = 0; r < 10; r++) begin
            wr_en0 = tbl[r].we0; wr_addr0 = tbl[r].a0; wr_data0 = tbl[r].d0;
            wr_en1 = tbl[r].we1; wr_addr1 = tbl[r].a1; wr_data1 = tbl[r].d1;
            rd_addr = {tbl[r].ra1, tbl[r].ra0};
            push($sformatf("vec%0d_p0", r), 0, tbl[r].e0);
            push($sformatf("vec%0d_p1", r), 1, tbl[r].e1);
            @(negedge clk);
            drain();
            if (tbl[r].we0) model_wr(tbl[r].a0, tbl[r].d0);
            if (tbl[r].we1) model_wr(tbl[r].a1, tbl[r].d1);
            tick();
        end
        idle_inputs();

        // ---- 4: same-cycle read of a write target ----
        wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 32'hABCD;
        rd_addr = {5'd1, 5'd9};
`ifdef REGFILE_BYPASS_EN
        push("bypass_same", 0, 32'hABCD);
`else
        push("bypass_same", 0, model[9]);
`endif
        @(negedge clk);
        drain();
        model_wr(5'd9, 32'hABCD);
        tick();
        idle_inputs();
        push("bypass_next", 0, 32'hABCD);
        @(negedge clk);
        drain();

        // ---- 5: full scrub with ignored write and ignored second clr_req ----
        tick();
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 36; c++) begin
            rd_addr = {5'd20, 5'd5};
            wr_en0  = (c == 10); wr_addr0 = 5'd20; wr_data0 = 32'd1;
            clr_req = (c == 15);
            if (c < DEPTH) begin
                push($sformatf("scrub_r5_c%0d", c),  0, (c > 5)  ? 32'd0 : model[5]);
                push($sformatf("scrub_r20_c%0d", c), 1, (c > 20) ? 32'd0 : model[20]);
            end
            @(negedge clk);
            drain();
            if (busy) busy_cnt++;
            tick();
        end
        idle_inputs();
        chk("scrub_busy_cycles", 32'(busy_cnt), 32'd32);
        model_clear();
        read_all("scrub_read");

        // ---- 6: reset mid-scrub, then a fresh full scrub ----
        tick();
        fill_all();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        read_all("abort_read");
        tick();
        wr_en0 = 1'b1; wr_addr0 = 5'd17; wr_data0 = 32'h55;
        tick();
        idle_inputs();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            tick();
        end
        chk("rescrub_busy_cycles", 32'(busy_cnt), 32'd32);
        read_all("rescrub_read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
